// File: rtl/mem_wb_stage_if.sv
// MEM/WB boundary bundle: memory-stage result and handshake in, register-file write,
// forwarding and retire information out.
interface mem_wb_stage_if #(
  parameter int unsigned addr_width = 64,
  parameter int unsigned data_width = 64
);
  logic                  memory_done;
  logic [data_width-1:0] loaded_data;
  logic [data_width-1:0] alu_data;
  logic                  read_memory_access;
  logic                  reg_write;
  logic [4:0]            dest_reg;
  logic [addr_width-1:0] pc;
  logic                  wb_hold;

  logic                  mem_wb_pipeline_valid;
  logic                  rf_we;
  logic [4:0]            rf_waddr;
  logic [data_width-1:0] rf_wdata;
  logic                  fwd_valid;
  logic [4:0]            fwd_reg;
  logic [data_width-1:0] fwd_data;
  logic                  retire_pulse;
  logic [addr_width-1:0] retire_pc;
  logic [63:0]           instret;

  // Memory stage and register-file side.
  modport master (
    output memory_done, loaded_data, alu_data, read_memory_access, reg_write, dest_reg, pc,
           wb_hold,
    input  mem_wb_pipeline_valid, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_reg, fwd_data,
           retire_pulse, retire_pc, instret
  );

  // Writeback stage side.
  modport slave (
    input  memory_done, loaded_data, alu_data, read_memory_access, reg_write, dest_reg, pc,
           wb_hold,
    output mem_wb_pipeline_valid, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_reg, fwd_data,
           retire_pulse, retire_pc, instret
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Writeback stage: captures a memory-stage result, commits it once to the register file and
// forwards it while held. Define WB_RETIRE_COUNT_EN to build the 64-bit instret counter.
module mem_wb_stage #(
  parameter int unsigned addr_width = 64,
  parameter int unsigned data_width = 64
) (
  input logic           clk,
  input logic           reset,
  mem_wb_stage_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StWrite, StWaitDrop} state_e;

  state_e                state_q;
  logic                  valid_q;
  logic                  we_q;
  logic [4:0]            reg_q;
  logic [data_width-1:0] data_q;
  logic [addr_width-1:0] pc_q;
  logic                  commit;

  assign commit = (state_q == StWrite) && !bus.wb_hold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      reg_q   <= '0;
      data_q  <= '0;
      pc_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.memory_done) begin
            state_q <= StWrite;
            valid_q <= 1'b1;
            data_q  <= bus.read_memory_access ? bus.loaded_data : bus.alu_data;
            reg_q   <= bus.dest_reg;
            we_q    <= bus.reg_write && (bus.dest_reg != 5'd0);
            pc_q    <= bus.pc;
          end
        end
        StWrite: begin
          if (!bus.wb_hold) state_q <= StWaitDrop;
        end
        StWaitDrop: begin
          // A still-high done belongs to the result already committed.
          if (!bus.memory_done) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_wb_pipeline_valid = valid_q;
  assign bus.rf_we                 = commit && we_q;
  assign bus.rf_waddr              = reg_q;
  assign bus.rf_wdata              = data_q;
  assign bus.retire_pulse          = commit;
  assign bus.retire_pc             = pc_q;
  assign bus.fwd_valid             = valid_q && we_q;
  assign bus.fwd_reg               = reg_q;
  assign bus.fwd_data              = data_q;

`ifdef WB_RETIRE_COUNT_EN
  logic [63:0] instret_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instret_q <= '0;
    end else if (commit) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign bus.instret = instret_q;
`else
  assign bus.instret = '0;
`endif

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Writeback stage sitting directly downstream of the memory stage. It captures the memory stage's result on the `memory_done` level handshake, holds it in the MEM/WB pipeline register, commits it to the integer register file with one write pulse, and answers with `mem_wb_pipeline_valid` so the memory stage can drop `memory_done`. While a result is held, it also exposes that result for forwarding, and optionally keeps a retired-instruction count.

## Interface
Parameters:
- `addr_width`, 64, width of the PC field carried for debug/retire.
- `data_width`, 64, register data width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `memory_done`  in  1  memory-stage result ready; level, held until `mem_wb_pipeline_valid` is seen.
- `loaded_data`  in  data_width  load result, already size- and sign-adjusted.
- `alu_data`  in  data_width  ALU result from the memory stage.
- `read_memory_access`  in  1  instruction is a load; selects `loaded_data`.
- `reg_write`  in  1  instruction writes `dest_reg`.
- `dest_reg`  in  5  destination register index.
- `pc`  in  addr_width  instruction PC.
- `wb_hold`  in  1  register file busy (e.g. ecall in progress); defers the commit.
- `mem_wb_pipeline_valid`  out  1  result captured; acknowledges the memory stage.
- `rf_we`  out  1  register-file write enable, one cycle per instruction.
- `rf_waddr`  out  5  write address.
- `rf_wdata`  out  data_width  write data.
- `fwd_valid`  out  1  forwarding bus holds a live result.
- `fwd_reg`  out  5  forwarded register index.
- `fwd_data`  out  data_width  forwarded value.
- `retire_pulse`  out  1  one-cycle pulse when an instruction commits.
- `retire_pc`  out  addr_width  PC of the committing instruction.
- `instret`  out  64  retired-instruction count (see Configuration).

## Operation
- FSM with three states: IDLE, WRITE, WAIT_DROP.
- IDLE:
  - When `memory_done`=1, latch the result and go to WRITE.
  - Latched fields: `wb_data` = `read_memory_access` ? `loaded_data` : `alu_data`; `dest_reg`; effective write flag = `reg_write` && `dest_reg`!=0; `pc`.
- WRITE:
  - `mem_wb_pipeline_valid`=1.
  - If `wb_hold`=0: `rf_we` = effective write flag and `retire_pulse`=1 (combinational from state and latched data); next state is WAIT_DROP.
  - If `wb_hold`=1: `rf_we`=0, `retire_pulse`=0, stay in WRITE.
- WAIT_DROP:
  - `mem_wb_pipeline_valid`=1.
  - Stay until `memory_done`=0 is sampled, then go to IDLE.
  - This stops one memory-stage result from being captured twice.
- Register-file and retire outputs:
  - `rf_waddr`/`rf_wdata` always show the latched register and data.
  - `retire_pc` always shows the latched PC.
- Forwarding:
  - `fwd_valid`=1 in WRITE and in WAIT_DROP, and only if the effective write flag is set.
  - `fwd_reg`/`fwd_data` = latched register and data.
  - x0 is never forwarded.
- Writes to x0 are suppressed, but the instruction still retires (`retire_pulse`=1).
- The latched data register updates only on capture. It is stable from WRITE through WAIT_DROP.

## Timing
- Reset (asynchronous assert):
  - State = IDLE; all latched fields = 0.
  - Outputs: `mem_wb_pipeline_valid`=0, `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `fwd_valid`=0, `fwd_reg`=0, `fwd_data`=0, `retire_pulse`=0, `retire_pc`=0, `instret`=0.
  - Reset mid-operation discards the held result and performs no write.
  - Release is synchronous to the clock edge.
- Latency:
  - `memory_done` sampled high at edge N → WRITE during cycle N+1, with `rf_we` high in that cycle (given no hold).
  - The register file commits at edge N+2.
  - Minimum IDLE→IDLE loop is 3 cycles. The memory stage drops `memory_done` combinationally on valid, so WAIT_DROP lasts one cycle.
- `mem_wb_pipeline_valid` is registered and glitch-free. It goes high the cycle after capture and stays high until the cycle after `memory_done`=0 is sampled in WAIT_DROP.
- A `memory_done` pulse shorter than one cycle is not required to be captured. The memory stage holds it as a level.
- `wb_hold` high for K cycles delays `rf_we`/`retire_pulse` by exactly K cycles. No write is lost.
- `rf_we` is never high for more than one cycle per capture.

## Configuration
- `WB_RETIRE_COUNT_EN` defined:
  - `instret` is a 64-bit counter, reset to 0.
  - It increments by 1 on each cycle with `retire_pulse`=1, including writes to x0.
  - It wraps from all-ones to 0.
- Not defined: `instret` is tied to 0 and no counter flops are synthesized.

## Test plan
- ALU op: `memory_done`=1, `alu_data`=0x1234, `read_memory_access`=0, `reg_write`=1, `dest_reg`=5 → valid high at N+1, `rf_we`=1 with `rf_waddr`=5 / `rf_wdata`=0x1234 for exactly one cycle, back to IDLE at N+3.
- Load select: `loaded_data`=0xFFFF_FFFF_FFFF_FF80, `alu_data`=0x8000, `read_memory_access`=1, `dest_reg`=10 → `rf_wdata`=0xFFFF_FFFF_FFFF_FF80, `fwd_data` identical while valid.
- x0: `dest_reg`=0, `reg_write`=1 → `rf_we`=0, `fwd_valid`=0, `retire_pulse`=1, `instret`+1 when enabled.
- Hold: `wb_hold`=1 for 4 cycles in WRITE → `rf_we` asserted once, 4 cycles late, latched data unchanged.
- Stale done: keep `memory_done` high 3 extra cycles after valid → single `rf_we`, FSM stays in WAIT_DROP until `memory_done`=0.
- Reset in WRITE: assert `reset`=0 mid-cycle → all outputs 0 immediately, no `rf_we`, `instret` unchanged from 0.
